seven_seg_display_ctrl: RTL and testbench

- Parametrised successor to the per-pair binary-to-seven-segment display logic on the DE2-115 board.
- Converts an IN_WIDTH-bit unsigned value into NUM_DIGITS active-low seven-segment digit codes.
- Decimal conversion is a sequential shift-and-add-3 (double dabble), one bit per clock. Hex mode is a direct nibble mapping.
- Adds leading-zero blanking, overflow indication and a load/busy/done handshake. Sits between a Qsys PIO export and the HEXn pins.

---
 rtl/seven_seg_display_ctrl_if.sv | 25 ++
 rtl/seven_seg_display_ctrl.sv | 139 +++++++++++++
 tb/tb_seven_seg_display_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_display_ctrl_if.sv
// Request/result bundle between the PIO export and the
// seven-segment display controller.
interface seven_seg_display_ctrl_if #(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 4
);
  logic [IN_WIDTH-1:0]     binary;
  logic                    load;
  logic                    hex_mode;
  logic                    blank_lz;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] segs;

  modport master (
    output binary, load, hex_mode, blank_lz,
    input  busy, done, overflow, segs
  );

  modport slave (
    input  binary, load, hex_mode, blank_lz,
    output busy, done, overflow, segs
  );
endinterface

// File: rtl/seven_seg_display_ctrl.sv
// Binary to active-low seven-segment converter: serial double
// dabble for decimal, direct nibble map for hex.
module seven_seg_display_ctrl #(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic clk,
  input  logic reset,
  seven_seg_display_ctrl_if.slave bus
);
  localparam int HW = 4 * NUM_DIGITS;
  localparam int XW = (IN_WIDTH > HW) ? IN_WIDTH : HW;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [IN_WIDTH-1:0]     sh;
  logic [HW-1:0]           bcd;
  logic [HW-1:0]           bcd_adj;
  logic [CW-1:0]           cnt;
  logic                    hex;
  logic                    blank;
  logic                    ovf_dec;
  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic                    ovf_reg;
  logic [XW-1:0]           hex_val;
  logic                    hex_ovf;
  logic                    ovf_new;
  logic                    accept;
  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0][6:0] seg_new;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign accept = (state == IDLE) && bus.load;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (bus.load)
                state_nxt = bus.hex_mode ? OUTPUT : SHIFT;
      SHIFT:  if (cnt == CW'(1)) state_nxt = OUTPUT;
      OUTPUT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      hex     <= 1'b0;
      blank   <= 1'b0;
      ovf_dec <= 1'b0;
      seg_reg <= '1;
      ovf_reg <= 1'b0;
    end else begin
      if (accept) begin
        sh      <= bus.binary;
        hex     <= bus.hex_mode;
        blank   <= bus.blank_lz;
        bcd     <= '0;
        ovf_dec <= 1'b0;
        cnt     <= CW'(IN_WIDTH);
      end
      if (state == SHIFT) begin
        bcd <= {bcd_adj[HW-2:0], sh[IN_WIDTH-1]};
        sh  <= sh << 1;
        cnt <= cnt - CW'(1);
        if (bcd_adj[HW-1]) ovf_dec <= 1'b1;
      end
      if (state == OUTPUT) begin
        seg_reg <= seg_new;
        ovf_reg <= ovf_new;
      end
    end
  end

  assign hex_val = XW'(sh);
  assign hex_ovf = |(hex_val >> HW);
  assign ovf_new = hex ? hex_ovf : ovf_dec;

  // Scan from the top digit so blanking stops at the first nonzero.
  always_comb begin
    logic lead;
    lead    = 1'b1;
    nib     = '0;
    seg_new = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib[k] = hex ? hex_val[4*k +: 4] : bcd[4*k +: 4];
      if (nib[k] != 4'd0 || k == 0) lead = 1'b0;
      if (ovf_new)             seg_new[k] = 7'h3F;
      else if (blank && lead)  seg_new[k] = 7'h7F;
      else                     seg_new[k] = enc(nib[k]);
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == OUTPUT);
  assign bus.segs     = bus.done ? seg_new : seg_reg;
  assign bus.overflow = bus.done ? ovf_new : ovf_reg;
endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl (16-bit, 4 digits).
module tb_seven_seg_display_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   n;
  int   dn;
  int   lat;
  logic [27:0] seg_at;

  seven_seg_display_ctrl_if #(.IN_WIDTH(16), .NUM_DIGITS(4)) bus ();

  seven_seg_display_ctrl #(.IN_WIDTH(16), .NUM_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] val,
                     input logic hx, input logic bl, input int exp_lat,
                     input logic [27:0] exp_segs, input logic exp_ovf);
    int k;
    bus.binary   = val;
    bus.hex_mode = hx;
    bus.blank_lz = bl;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    k = 1;
    while (!bus.done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_segs"}, bus.segs, exp_segs);
    chk({tag, "_ovf"}, bus.overflow, exp_ovf);
    chk({tag, "_busy"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_done_end"}, bus.done, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_hold"}, bus.segs, exp_segs);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.binary   = '0;
    bus.load     = 1'b0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_segs", bus.segs, 28'hFFFFFFF);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    run("dec1234", 16'd1234, 0, 0, 17,
        {7'h79, 7'h24, 7'h30, 7'h19}, 0);
    run("dec12345", 16'd12345, 0, 0, 17, {4{7'h3F}}, 1);
    run("dec9999", 16'd9999, 0, 0, 17, {4{7'h10}}, 0);
    run("hexBEEF", 16'hBEEF, 1, 0, 1,
        {7'h03, 7'h06, 7'h06, 7'h0E}, 0);
    run("blank7", 16'd7, 0, 1, 17,
        {7'h7F, 7'h7F, 7'h7F, 7'h78}, 0);
    run("blank0", 16'd0, 0, 1, 17,
        {7'h7F, 7'h7F, 7'h7F, 7'h40}, 0);
    run("blank1005", 16'd1005, 0, 1, 17,
        {7'h79, 7'h40, 7'h40, 7'h12}, 0);
    run("hexA5", 16'h00A5, 1, 1, 1,
        {7'h7F, 7'h7F, 7'h08, 7'h12}, 0);
    run("dec65535", 16'd65535, 0, 1, 17, {4{7'h3F}}, 1);

    // Second load at cycle 5 lands mid-conversion and must vanish.
    bus.binary   = 16'd4321;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n  = 1;
    dn = 0;
    lat = 0;
    seg_at = '0;
    while (n < 40) begin
      if (bus.done) begin
        dn++;
        lat    = n;
        seg_at = bus.segs;
      end
      if (n == 5) begin
        chk("hs_busy5", bus.busy, 1);
        bus.binary = 16'd1111;
        bus.load   = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("hs_ndone", dn, 1);
    chk("hs_lat", lat, 17);
    chk("hs_segs", seg_at, {7'h19, 7'h30, 7'h24, 7'h79});

    // Load held through the done cycle is taken one cycle later.
    bus.binary   = 16'h1234;
    bus.hex_mode = 1'b1;
    bus.load     = 1'b1;
    @(negedge clk);
    chk("dl_done", bus.done, 1);
    chk("dl_segs", bus.segs, {7'h79, 7'h24, 7'h30, 7'h19});
    bus.binary   = 16'd5555;
    bus.hex_mode = 1'b0;
    @(negedge clk);
    chk("dl_ignored", bus.busy, 0);
    @(negedge clk);
    bus.load = 1'b0;
    n = 1;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("dl_lat", n, 17);
    chk("dl_segs2", bus.segs, {4{7'h12}});
    @(negedge clk);

    // Reset ten cycles into a conversion aborts it.
    bus.binary = 16'd8888;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ab_segs", bus.segs, 28'hFFFFFFF);
    chk("ab_busy", bus.busy, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_ovf", bus.overflow, 0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("ab_nodone", dn, 0);
    chk("ab_segs_end", bus.segs, 28'hFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
